// File: rtl/pulse_mode_input_conditioner.sv
// Turns raw, bouncy S3/S2 push-buttons into debounced, mutually exclusive single pulses on x1/x2
// with a quiet gap between them, for the downstream pulse-mode sequence detector.
module pulse_mode_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned PULSE_WIDTH     = 1000,
    parameter int unsigned GAP_CYCLES      = 1000
) (
    input  logic cp,
    input  logic rst,
    input  logic btn_3,
    input  logic btn_2,
    output logic x1,
    output logic x2,
    output logic busy,
    output logic conflict
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int unsigned GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Channel vectors: bit 1 is S3 (btn_3), bit 0 is S2 (btn_2).
    logic [1:0]      meta_q, sync_q, stab_q, stab_d, stab_prev_q, vld_q, rise;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic            arm_q, arm_d;
    logic            clash;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic [PW_W-1:0] wcnt_q, wcnt_d;
    logic [GP_W-1:0] gcnt_q, gcnt_d;
    logic            x1_d, x2_d, busy_d, conflict_d;

    // Synchronizers, debounce state and post-reset arming.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            meta_q      <= '0;
            sync_q      <= '0;
            stab_q      <= '0;
            stab_prev_q <= '0;
            vld_q       <= '0;
            cnt_q       <= '{default: '0};
            arm_q       <= 1'b0;
        end else begin
            meta_q      <= {btn_3, btn_2};
            sync_q      <= meta_q;
            stab_q      <= stab_d;
            stab_prev_q <= stab_q;
            vld_q       <= {vld_q[0], 1'b1};
            cnt_q       <= cnt_d;
            arm_q       <= arm_d;
        end
    end

    always_comb begin
        stab_d = stab_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stab_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stab_d[i] = ~stab_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // A button still held across reset must be released before its press counts.
    assign arm_d = arm_q | (vld_q[1] & ~|sync_q & ~|stab_q);
    assign rise  = stab_q & ~stab_prev_q;
    assign clash = (rise[1] & stab_q[0]) | (rise[0] & stab_q[1]);

    // Arbiter state register.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Arbiter next state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (arm_q) begin
                    if (clash) begin
                        state_d = HOLD;
                    end else if (rise[1]) begin
                        state_d = PULSE;
                        sel_d   = 1'b1;
                        wcnt_d  = PW_LAST;
                    end else if (rise[0]) begin
                        state_d = PULSE;
                        sel_d   = 1'b0;
                        wcnt_d  = PW_LAST;
                    end
                end
            end
            PULSE: begin
                if (wcnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    wcnt_d = wcnt_q - PW_W'(1);
                end
            end
            HOLD: begin
                if (stab_q == 2'b00) begin
                    state_d = GAP;
                    gcnt_d  = GP_LAST;
                end
            end
            GAP: begin
                if (stab_q != 2'b00) begin
                    state_d = HOLD;
                end else if (gcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - GP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter outputs, taken from the upcoming state so x1/x2 register on the accepting edge.
    always_comb begin
        x1_d       = 1'b0;
        x2_d       = 1'b0;
        busy_d     = 1'b0;
        conflict_d = 1'b0;
        if (state_d == PULSE) begin
            x1_d = sel_d;
            x2_d = ~sel_d;
        end
        busy_d     = (state_d != IDLE);
        conflict_d = (state_q == IDLE) & arm_q & clash;
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            x1       <= 1'b0;
            x2       <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            x1       <= x1_d;
            x2       <= x2_d;
            busy     <= busy_d;
            conflict <= conflict_d;
        end
    end

endmodule

// File: tb/tb_pulse_mode_input_conditioner.sv
// Bench for pulse_mode_input_conditioner: directed scenarios plus random button activity,
// each compared cycle by cycle against a deadline-based behavioural model.
module tb_pulse_mode_input_conditioner;

    localparam int DB = 4;
    localparam int PW = 2;
    localparam int GP = 3;
    localparam int M_IDLE  = 0;
    localparam int M_PULSE = 1;
    localparam int M_HOLD  = 2;
    localparam int M_GAP   = 3;

    typedef bit bitq_t[$];

    logic cp = 1'b0;
    logic rst = 1'b1;
    logic btn_3 = 1'b0;
    logic btn_2 = 1'b0;
    logic x1, x2, busy, conflict;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int       m_n;
    bit [1:0] bq[$];
    bitq_t    h3, h2;
    bit [1:0] m_stab, m_prev;
    bit       m_arm;
    int       mode;
    int       t_end;
    bit       msel;
    bit       e_x1, e_x2, e_busy, e_conf;

    pulse_mode_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_WIDTH    (PW),
        .GAP_CYCLES     (GP)
    ) dut (
        .cp      (cp),
        .rst     (rst),
        .btn_3   (btn_3),
        .btn_2   (btn_2),
        .x1      (x1),
        .x2      (x2),
        .busy    (busy),
        .conflict(conflict)
    );

    always #5 cp = ~cp;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // True when the last DB synchronized samples all disagree with the current level.
    function automatic bit all_differ(input bitq_t q, input bit lvl);
        if (q.size() < DB) return 1'b0;
        for (int k = 0; k < DB; k++) begin
            if (q[q.size() - 1 - k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        bq     = '{2'b00, 2'b00};
        h3.delete();
        h2.delete();
        m_stab = 2'b00;
        m_prev = 2'b00;
        m_arm  = 1'b0;
        mode   = M_IDLE;
        t_end  = 0;
        msel   = 1'b0;
        e_x1   = 1'b0;
        e_x2   = 1'b0;
        e_busy = 1'b0;
        e_conf = 1'b0;
    endtask

    task automatic model_edge(input bit b3, input bit b2);
        bit [1:0] sv, rise, nstab;
        bit       clash;
        m_n++;
        sv = bq.pop_front();
        bq.push_back({b3, b2});
        rise   = m_stab & ~m_prev;
        clash  = (rise[1] & m_stab[0]) | (rise[0] & m_stab[1]);
        e_conf = 1'b0;
        case (mode)
            M_IDLE: begin
                if (m_arm) begin
                    if (clash) begin
                        mode   = M_HOLD;
                        e_conf = 1'b1;
                    end else if (rise != 2'b00) begin
                        mode  = M_PULSE;
                        msel  = rise[1];
                        t_end = m_n + PW;
                    end
                end
            end
            M_PULSE: if (m_n == t_end) mode = M_HOLD;
            M_HOLD: begin
                if (m_stab == 2'b00) begin
                    mode  = M_GAP;
                    t_end = m_n + GP;
                end
            end
            default: begin
                if (m_stab != 2'b00) mode = M_HOLD;
                else if (m_n == t_end) mode = M_IDLE;
            end
        endcase
        nstab = m_stab;
        h3.push_back(sv[1]);
        if (h3.size() > DB) void'(h3.pop_front());
        if (all_differ(h3, m_stab[1])) begin
            nstab[1] = ~m_stab[1];
            h3.delete();
        end
        h2.push_back(sv[0]);
        if (h2.size() > DB) void'(h2.pop_front());
        if (all_differ(h2, m_stab[0])) begin
            nstab[0] = ~m_stab[0];
            h2.delete();
        end
        if (m_n >= 3 && sv == 2'b00 && m_stab == 2'b00) m_arm = 1'b1;
        m_prev = m_stab;
        m_stab = nstab;
        e_x1   = (mode == M_PULSE) && msel;
        e_x2   = (mode == M_PULSE) && !msel;
        e_busy = (mode != M_IDLE);
    endtask

    task automatic step(input bit b3, input bit b2);
        btn_3 = b3;
        btn_2 = b2;
        @(posedge cp);
        model_edge(b3, b2);
        #1;
    endtask

    task automatic do_reset();
        btn_3 = 1'b0;
        btn_2 = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge cp);
        @(negedge cp);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            btn_3 = 1'($urandom_range(0, 1));
            btn_2 = 1'($urandom_range(0, 1));
            @(posedge cp);
            #1;
            n_checks++;
            if ({x1, x2, busy, conflict} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d x1/x2/busy/conflict got %b want 0000", i, {x1, x2, busy, conflict});
            end
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL reset_idle n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
        end
    endtask

    task automatic test_clean_press();
        int press_n, rel_n, first_x1, x1_cnt, x2_cnt, conf_cnt, busy_off;
        first_x1 = -1; x1_cnt = 0; x2_cnt = 0; conf_cnt = 0; busy_off = -1;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        press_n = m_n + 1;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) step(1'b1, 1'b0);
            else step(1'b0, 1'b0);
            if (i == 20) rel_n = m_n;
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL clean_press n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
            if (x1 === 1'b1) begin
                x1_cnt++;
                if (first_x1 < 0) first_x1 = m_n;
            end
            if (x2 === 1'b1) x2_cnt++;
            if (conflict === 1'b1) conf_cnt++;
            if (first_x1 >= 0 && busy_off < 0 && busy === 1'b0) busy_off = m_n;
        end
        n_checks++;
        if (first_x1 != press_n + DB + 2) begin
            n_fail++;
            $display("FAIL clean_latency first x1 edge got %0d want %0d", first_x1, press_n + DB + 2);
        end
        n_checks++;
        if ({x1_cnt, x2_cnt, conf_cnt} != {PW, 0, 0}) begin
            n_fail++;
            $display("FAIL clean_counts x1/x2/conflict cycles got %0d/%0d/%0d want %0d/0/0", x1_cnt, x2_cnt, conf_cnt, PW);
        end
        n_checks++;
        if (busy_off != rel_n + DB + 2 + GP) begin
            n_fail++;
            $display("FAIL clean_busy_end got edge %0d want %0d", busy_off, rel_n + DB + 2 + GP);
        end
    endtask

    task automatic test_bounce();
        bit [3:0] glitch;
        int x1_cnt, x2_cnt, x2_rises;
        bit px2;
        glitch = 4'b1010;
        x1_cnt = 0; x2_cnt = 0; x2_rises = 0; px2 = 1'b0;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        for (int i = 0; i < 31; i++) begin
            if (i < 4) step(1'b0, glitch[3 - i]);
            else if (i < 16) step(1'b0, 1'b1);
            else step(1'b0, 1'b0);
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL bounce n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
            if (x1 === 1'b1) x1_cnt++;
            if (x2 === 1'b1) x2_cnt++;
            if (x2 === 1'b1 && !px2) x2_rises++;
            px2 = (x2 === 1'b1);
        end
        n_checks++;
        if ({x1_cnt, x2_cnt, x2_rises} != {0, PW, 1}) begin
            n_fail++;
            $display("FAIL bounce_counts x1 cyc/x2 cyc/x2 pulses got %0d/%0d/%0d want 0/%0d/1", x1_cnt, x2_cnt, x2_rises, PW);
        end
    endtask

    task automatic test_simultaneous();
        int rel_n, conf_cnt, x_cnt, busy_off;
        conf_cnt = 0; x_cnt = 0; busy_off = -1;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        for (int i = 0; i < 26; i++) begin
            if (i < 10) step(1'b1, 1'b1);
            else step(1'b0, 1'b0);
            if (i == 10) rel_n = m_n;
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL simultaneous n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
            if (conflict === 1'b1) conf_cnt++;
            if (x1 === 1'b1 || x2 === 1'b1) x_cnt++;
            if (conf_cnt > 0 && busy_off < 0 && busy === 1'b0) busy_off = m_n;
        end
        n_checks++;
        if ({conf_cnt, x_cnt} != {1, 0}) begin
            n_fail++;
            $display("FAIL simul_counts conflict/pulse cycles got %0d/%0d want 1/0", conf_cnt, x_cnt);
        end
        n_checks++;
        if (busy_off != rel_n + DB + 2 + GP) begin
            n_fail++;
            $display("FAIL simul_busy_end got edge %0d want %0d", busy_off, rel_n + DB + 2 + GP);
        end
    endtask

    task automatic test_sequence();
        int order[$];
        int w, low;
        bit seen, px1, px2;
        w = 0; low = 0; seen = 1'b0; px1 = 1'b0; px2 = 1'b0;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        for (int i = 0; i < 80; i++) begin
            bit on;
            on = (i < 60) && ((i % 20) < 10);
            if (i < 20) step(on, 1'b0);
            else step(1'b0, on);
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL sequence n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
            if (x1 === 1'b1 && !px1) order.push_back(1);
            if (x2 === 1'b1 && !px2) order.push_back(2);
            px1 = (x1 === 1'b1);
            px2 = (x2 === 1'b1);
            if (px1 || px2) begin
                if (w == 0 && seen) begin
                    n_checks++;
                    if (low < GP) begin
                        n_fail++;
                        $display("FAIL seq_gap low cycles got %0d want >= %0d", low, GP);
                    end
                end
                w++;
                low = 0;
            end else begin
                if (w != 0) begin
                    n_checks++;
                    if (w != PW) begin
                        n_fail++;
                        $display("FAIL seq_width got %0d want %0d", w, PW);
                    end
                    seen = 1'b1;
                end
                w = 0;
                low++;
            end
        end
        n_checks++;
        if (order.size() != 3) begin
            n_fail++;
            $display("FAIL seq_order pulse count got %0d want 3", order.size());
        end else if ({order[0], order[1], order[2]} != {1, 2, 2}) begin
            n_fail++;
            $display("FAIL seq_order got %0d,%0d,%0d want 1,2,2", order[0], order[1], order[2]);
        end
    endtask

    task automatic test_held_second();
        int x1_rises, x2_cnt, conf_cnt;
        bit px1, got;
        x1_rises = 0; x2_cnt = 0; conf_cnt = 0; px1 = 1'b0; got = 1'b0;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (!got && i < 20) step(1'b1, 1'b0);
            else if (i < 28) step(1'b1, 1'b1);
            else if (i < 36) step(1'b0, 1'b1);
            else step(1'b0, 1'b0);
            if (x1 === 1'b1) got = 1'b1;
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL held_second n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
            if (x1 === 1'b1 && !px1) x1_rises++;
            px1 = (x1 === 1'b1);
            if (x2 === 1'b1) x2_cnt++;
            if (conflict === 1'b1) conf_cnt++;
        end
        n_checks++;
        if ({x1_rises, x2_cnt, conf_cnt} != {1, 0, 0}) begin
            n_fail++;
            $display("FAIL held_counts x1 pulses/x2 cyc/conflict got %0d/%0d/%0d want 1/0/0", x1_rises, x2_cnt, conf_cnt);
        end
    endtask

    task automatic test_async_reset();
        int guard, x1_cnt, x1_rises;
        bit px1;
        guard = 0; x1_cnt = 0; x1_rises = 0; px1 = 1'b0;
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        while (x1 !== 1'b1 && guard < 30) begin
            step(1'b1, 1'b0);
            guard++;
        end
        n_checks++;
        if (x1 !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_first_pulse x1 got %b want 1 within 30 cycles", x1);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if ({x1, busy} !== {e_x1, e_busy} || e_x1 !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_second_cycle x1/busy got %b want %b (model x1 %b)", {x1, busy}, {e_x1, e_busy}, e_x1);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({x1, x2, busy, conflict} !== 4'b0000) begin
            n_fail++;
            $display("FAIL arst_immediate got %b want 0000", {x1, x2, busy, conflict});
        end
        @(negedge cp);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 44; i++) begin
            if (i < 20) step(1'b1, 1'b0);
            else if (i < 32) step(1'b0, 1'b0);
            else step(1'b1, 1'b0);
            n_checks++;
            if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                n_fail++;
                $display("FAIL arst_after n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
            end
            if (i < 32 && x1 === 1'b1) x1_cnt++;
            if (i >= 32 && x1 === 1'b1 && !px1) x1_rises++;
            px1 = (x1 === 1'b1);
        end
        n_checks++;
        if ({x1_cnt, x1_rises} != {0, 1}) begin
            n_fail++;
            $display("FAIL arst_rearm held x1 cyc/repress pulses got %0d/%0d want 0/1", x1_cnt, x1_rises);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        for (int s = 0; s < 60; s++) begin
            bit b3, b2;
            int dur;
            b3  = 1'($urandom_range(0, 1));
            b2  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            dur = int'($urandom_range(1, 14));
            for (int i = 0; i < dur; i++) begin
                step(b3, b2);
                n_checks++;
                if ({x1, x2, busy, conflict} !== {e_x1, e_x2, e_busy, e_conf}) begin
                    n_fail++;
                    $display("FAIL random n=%0d got %b want %b", m_n, {x1, x2, busy, conflict}, {e_x1, e_x2, e_busy, e_conf});
                end
                n_checks++;
                if ((x1 & x2) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_exclusive n=%0d x1&x2 got %b want 0", m_n, x1 & x2);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_sequence();
        test_held_second();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_mode_input_conditioner.md
Name: pulse_mode_input_conditioner

Overview:
- Upstream stage for the x1-x2-x2 pulse-mode sequence detector on the EGO1 board.
- Converts raw push-buttons S3 (btn_3) and S2 (btn_2) into clean, debounced, mutually exclusive single pulses on x1 and x2.
- Guarantees the pulse-mode input rules the detector depends on: one pulse per press, never two inputs active at once, and a quiet gap between pulses.
- Also flags rejected simultaneous presses.

Parameters:
- DEBOUNCE_CYCLES, 2000000: consecutive cp cycles a synchronized input must differ from its stable level before the stable level changes (20 ms at 100 MHz).
- PULSE_WIDTH, 1000: number of cp cycles x1/x2 stay high per accepted press (10 us at 100 MHz); must be at least 1.
- GAP_CYCLES, 1000: minimum number of idle cp cycles after both buttons are released before a new press can be accepted; must be at least 1.

Ports:
- cp, input, 1: system clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-high reset.
- btn_3, input, 1: raw S3 button, asynchronous and bouncy; pressed = 1.
- btn_2, input, 1: raw S2 button, asynchronous and bouncy; pressed = 1.
- x1, output, 1: conditioned pulse for S3; registered.
- x2, output, 1: conditioned pulse for S2; registered.
- busy, output, 1: high whenever the arbiter state is not IDLE; registered.
- conflict, output, 1: one-cycle pulse when a simultaneous press is rejected; registered.

Behaviour:
- Reset: rst asserted at any time, including mid-pulse, immediately forces the following to 0:
  - all sync flops, debounce counters, and stable levels s3/s2;
  - x1, x2, busy, and conflict;
  - state = IDLE.
  - After rst deasserts, nothing is emitted until a fresh debounced rising edge occurs.
- Synchronizer: two flops per button; the outputs are sync_3 and sync_2.
- Debounce, per channel, independent of the other channel:
  - If sync equals the stable level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, the stable level toggles and the counter clears on that same edge.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: rise_3 and rise_2 are one-cycle flags marking a 0->1 transition of the stable level. They are combinational from the stable level and its registered copy.
- Arbiter FSM, with states IDLE, PULSE, HOLD, GAP:
  - IDLE:
    - rise_3 and not rise_2: sel = x1, load the width counter, go to PULSE.
    - rise_2 and not rise_3: sel = x2, load the width counter, go to PULSE.
    - rise_3 and rise_2 on the same cycle: conflict = 1 for one cycle, go to HOLD, and emit no pulse.
    - A rising edge on one channel while the other stable level is already high is also a conflict (that press is treated as simultaneous).
  - PULSE:
    - The selected output is high for exactly PULSE_WIDTH cycles; the other output stays 0.
    - Then go to HOLD.
  - HOLD:
    - Wait until s3 = 0 and s2 = 0.
    - Then load the gap counter and go to GAP.
    - Edges occurring here are ignored, and a second button pressed here is ignored.
  - GAP:
    - Count GAP_CYCLES cycles; go to IDLE when done.
    - If either stable level rises during GAP, return to HOLD and do not restart the gap.
- Output timing:
  - x1, x2, and conflict are registered from the FSM.
  - First cycle of x1 = posedge (DEBOUNCE_CYCLES + 3) counted from the first posedge sampling btn_3 high on a clean press (2 sync + DEBOUNCE_CYCLES debounce + 1 output register).
- Invariants:
  - x1 and x2 are never high together.
  - Exactly one pulse is emitted per accepted press, regardless of hold duration.
  - Release never generates a pulse.

Test Plan (parameters: DEBOUNCE_CYCLES=4, PULSE_WIDTH=2, GAP_CYCLES=3):
- Clean press btn_3 high for 20 cycles, then released -> x1 high exactly 2 cycles, starting at posedge 7 after btn_3 is first sampled high; x2 = 0; busy is high from the first x1 cycle until GAP completes; conflict = 0.
- btn_2 bounces 1,0,1,0 (1-cycle glitches), then stays high 12 cycles -> no pulse during the bounces; exactly one 2-cycle x2 pulse after the 4th stable cycle is reached.
- Both buttons rise on the same cycle and are held 10 cycles -> conflict = 1 for exactly 1 cycle; x1 = x2 = 0 throughout; busy stays high until both are released plus 3 gap cycles.
- Sequence S3, S2, S2, each held 10 cycles with 10 idle cycles between presses -> x1 pulse, x2 pulse, x2 pulse in that order, each 2 cycles wide, never overlapping, each separated by at least GAP_CYCLES low cycles.
- btn_3 held, then btn_2 pressed during PULSE/HOLD -> a single x1 pulse only; no x2 pulse and no conflict.
- rst asserted asynchronously during the second cycle of an x1 pulse -> x1, busy, and the state clear without waiting for a clock edge; after release, with btn_3 still held, no new pulse is emitted until btn_3 is released and re-pressed.
